// File: rtl/countdown_timer_core.sv
// Programmable up/down HH:MM:SS-style BCD timer with prescaler, pause and sticky alarm.
// Optional ALARM_BLINK_EN: half-second blink of alarm while in DONE.
module countdown_timer_core #(
  parameter int TICKS_PER_SEC = 10000,
  parameter int NUM_PAIRS     = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [8*NUM_PAIRS-1:0] preset_bcd,
  input  logic                   mode,
  input  logic                   start,
  input  logic                   pause,
  input  logic                   clear,
  output logic [8*NUM_PAIRS-1:0] digits_bcd,
  output logic                   running,
  output logic                   paused,
  output logic                   alarm,
  output logic                   alarm_blink,
  output logic                   load_err
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam int DW = 8 * NUM_PAIRS;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t          state, state_n;
  logic [PW-1:0]   presc;
  logic [DW-1:0]   preset, cnt;
  logic            mode_q;

  function automatic logic [DW-1:0] bcd_dec(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    logic          b;
    logic [3:0]    o, t;
    r = '0;
    b = 1'b1;
    for (int p = 0; p < NUM_PAIRS; p++) begin
      o = v[8*p +: 4];
      t = v[8*p+4 +: 4];
      if (b) begin
        if (o != 4'd0) begin
          o = o - 4'd1;
          b = 1'b0;
        end else begin
          o = 4'd9;
          if (t != 4'd0) begin
            t = t - 4'd1;
            b = 1'b0;
          end else begin
            t = 4'd5;
          end
        end
      end
      r[8*p +: 8] = {t, o};
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] bcd_inc(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    logic          c;
    logic [3:0]    o, t;
    r = '0;
    c = 1'b1;
    for (int p = 0; p < NUM_PAIRS; p++) begin
      o = v[8*p +: 4];
      t = v[8*p+4 +: 4];
      if (c) begin
        if (o != 4'd9) begin
          o = o + 4'd1;
          c = 1'b0;
        end else begin
          o = 4'd0;
          if (t != 4'd5) begin
            t = t + 4'd1;
            c = 1'b0;
          end else begin
            t = 4'd0;
          end
        end
      end
      r[8*p +: 8] = {t, o};
    end
    return r;
  endfunction

  function automatic logic bcd_ok(input logic [DW-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int p = 0; p < NUM_PAIRS; p++) begin
      if (v[8*p +: 4] > 4'd9 || v[8*p+4 +: 4] > 4'd5) ok = 1'b0;
    end
    return ok;
  endfunction

  logic          idle_done, sec_tick, tick_done;
  logic          do_load, do_start, do_pause;
  logic [DW-1:0] cnt_next;

  // Priority masking: clear > load > start > pause
  assign do_load   = !clear && load;
  assign do_start  = !clear && !load && start;
  assign do_pause  = !clear && !load && !start && pause;
  assign idle_done = (state == IDLE) || (state == DONE);
  assign sec_tick  = (state == RUN) && (presc == PW'(TICKS_PER_SEC - 1));
  assign cnt_next  = mode_q ? bcd_dec(cnt) : bcd_inc(cnt);
  assign tick_done = sec_tick &&
                     (mode_q ? (cnt_next == '0) : (cnt_next == preset));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (clear) begin
      state_n = IDLE;
    end else if (do_start && idle_done) begin
      state_n = (preset == '0) ? DONE : RUN;
    end else if (tick_done) begin
      state_n = DONE;
    end else if (do_pause && state == RUN) begin
      state_n = PAUSE;
    end else if (do_pause && state == PAUSE) begin
      state_n = RUN;
    end
  end

  always_comb begin
    running = 1'b0;
    paused  = 1'b0;
    unique case (state)
      RUN:     running = 1'b1;
      PAUSE:   paused  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc    <= '0;
      preset   <= '0;
      cnt      <= '0;
      mode_q   <= 1'b0;
      alarm    <= 1'b0;
      load_err <= 1'b0;
    end else begin
      load_err <= 1'b0;
      if (clear) begin
        cnt   <= '0;
        presc <= '0;
        alarm <= 1'b0;
      end else if (do_load && idle_done) begin
        if (bcd_ok(preset_bcd)) preset   <= preset_bcd;
        else                    load_err <= 1'b1;
      end else if (do_start && idle_done) begin
        mode_q <= mode;
        presc  <= '0;
        alarm  <= (preset == '0);
        cnt    <= mode ? preset : '0;
      end else if (state == RUN) begin
        presc <= sec_tick ? '0 : presc + PW'(1);
        if (sec_tick)  cnt   <= cnt_next;
        if (tick_done) alarm <= 1'b1;
      end
    end
  end

  assign digits_bcd = cnt;

`ifdef ALARM_BLINK_EN
  localparam int HALF = TICKS_PER_SEC / 2;
  localparam int HW   = $clog2(HALF + 1);

  logic [HW-1:0] half_cnt;
  logic          blink;

  // Blink restarts high on every DONE entry, then toggles each half second
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_cnt <= '0;
      blink    <= 1'b0;
    end else if (state_n != DONE) begin
      half_cnt <= '0;
      blink    <= 1'b0;
    end else if (state != DONE) begin
      half_cnt <= '0;
      blink    <= 1'b1;
    end else if (half_cnt == HW'(HALF - 1)) begin
      half_cnt <= '0;
      blink    <= ~blink;
    end else begin
      half_cnt <= half_cnt + HW'(1);
    end
  end

  assign alarm_blink = blink;
`else
  assign alarm_blink = alarm;
`endif

endmodule

// File: tb/tb_countdown_timer_core.sv
// Directed bench for countdown_timer_core with TICKS_PER_SEC=4, three digit pairs.
// Checks the blink pattern when built with ALARM_BLINK_EN.
module tb_countdown_timer_core;

  localparam int T  = 4;
  localparam int NP = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          load, mode, start, pause, clear;
  logic [8*NP-1:0] preset_bcd;
  logic [8*NP-1:0] digits_bcd;
  logic          running, paused, alarm, alarm_blink, load_err;

  int n_tests = 0;
  int n_fail  = 0;

  countdown_timer_core #(.TICKS_PER_SEC(T), .NUM_PAIRS(NP)) dut (
    .clk(clk), .rst(rst), .load(load), .preset_bcd(preset_bcd),
    .mode(mode), .start(start), .pause(pause), .clear(clear),
    .digits_bcd(digits_bcd), .running(running), .paused(paused),
    .alarm(alarm), .alarm_blink(alarm_blink), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [8*NP-1:0] v);
    preset_bcd = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic do_start(input logic m);
    mode = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_pause();
    pause = 1'b1;
    @(negedge clk);
    pause = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    load = 0; mode = 0; start = 0; pause = 0; clear = 0;
    preset_bcd = '0;
    cyc(2);
    chk("rst_digits", digits_bcd, 0);
    chk("rst_running", running, 0);
    chk("rst_paused", paused, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_blink", alarm_blink, 0);
    chk("rst_lerr", load_err, 0);
    rst = 1'b0;
    cyc(1);

    // down count 3 -> 0
    do_load(24'h000003);
    chk("t1_lerr", load_err, 0);
    do_start(1'b1);
    chk("t1_run", running, 1);
    chk("t1_d3", digits_bcd, 24'h000003);
    cyc(3);
    chk("t1_d3_hold", digits_bcd, 24'h000003);
    cyc(1);
    chk("t1_d2", digits_bcd, 24'h000002);
    cyc(4);
    chk("t1_d1", digits_bcd, 24'h000001);
    cyc(3);
    chk("t1_pre_alarm", alarm, 0);
    cyc(1);
    chk("t1_d0", digits_bcd, 24'h000000);
    chk("t1_alarm", alarm, 1);
    chk("t1_run_drop", running, 0);
`ifdef ALARM_BLINK_EN
    chk("t6_blink0", alarm_blink, 1);
    cyc(1);
    chk("t6_blink1", alarm_blink, 1);
    cyc(1);
    chk("t6_blink2", alarm_blink, 0);
    cyc(1);
    chk("t6_blink3", alarm_blink, 0);
    cyc(1);
    chk("t6_blink4", alarm_blink, 1);
    chk("t6_alarm_held", alarm, 1);
`else
    chk("t6_blink_eq", alarm_blink, 1);
    cyc(4);
    chk("t6_alarm_held", alarm, 1);
    chk("t6_d_frozen", digits_bcd, 24'h000000);
`endif

    // borrow across pair, then up count
    do_load(24'h000100);
    do_start(1'b1);
    chk("t2_d100", digits_bcd, 24'h000100);
    chk("t2_alarm_clr", alarm, 0);
    cyc(4);
    chk("t2_d059", digits_bcd, 24'h000059);
    do_clear();
    chk("t2_clr_d", digits_bcd, 0);
    chk("t2_clr_run", running, 0);
    do_load(24'h000002);
    do_start(1'b0);
    chk("t2_up0", digits_bcd, 24'h000000);
    cyc(4);
    chk("t2_up1", digits_bcd, 24'h000001);
    chk("t2_up1_alarm", alarm, 0);
    cyc(4);
    chk("t2_up2", digits_bcd, 24'h000002);
    chk("t2_up_alarm", alarm, 1);
    chk("t2_up_run", running, 0);

    // pause and resume
    do_load(24'h000005);
    do_start(1'b1);
    cyc(4);
    chk("t3_d4", digits_bcd, 24'h000004);
    cyc(1);
    do_pause();
    chk("t3_paused", paused, 1);
    chk("t3_notrun", running, 0);
    cyc(10);
    chk("t3_hold_p", paused, 1);
    chk("t3_hold_d", digits_bcd, 24'h000004);
    do_pause();
    chk("t3_resume", running, 1);
    chk("t3_unpaused", paused, 0);
    cyc(1);
    chk("t3_r1", digits_bcd, 24'h000004);
    cyc(1);
    chk("t3_r2", digits_bcd, 24'h000003);

    // load in RUN ignored, bad load rejected
    do_load(24'h000009);
    chk("t4_run_lerr", load_err, 0);
    chk("t4_run_d", digits_bcd, 24'h000003);
    do_clear();
    do_load(24'h000065);
    chk("t4_bad_lerr", load_err, 1);
    cyc(1);
    chk("t4_lerr_pulse", load_err, 0);
    do_load(24'h00A000);
    chk("t4_bad2_lerr", load_err, 1);
    do_start(1'b1);
    chk("t4_old_preset", digits_bcd, 24'h000005);
    do_clear();

    // zero preset, clear beats start
    do_load(24'h000000);
    do_start(1'b0);
    chk("t5_up_alarm", alarm, 1);
    chk("t5_up_run", running, 0);
    chk("t5_up_d", digits_bcd, 0);
    clear = 1'b1;
    start = 1'b1;
    cyc(1);
    clear = 1'b0;
    start = 1'b0;
    chk("t5_clr_alarm", alarm, 0);
    chk("t5_clr_d", digits_bcd, 0);
    chk("t5_clr_run", running, 0);
    do_start(1'b1);
    chk("t5_dn_alarm", alarm, 1);
    do_clear();

    // async reset mid-run
    do_load(24'h000010);
    do_start(1'b1);
    cyc(4);
    chk("t6_d09", digits_bcd, 24'h000009);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_arst_d", digits_bcd, 0);
    chk("t6_arst_run", running, 0);
    chk("t6_arst_alarm", alarm, 0);
    chk("t6_arst_blink", alarm_blink, 0);
    cyc(1);
    rst = 1'b0;
    cyc(2);
    chk("t6_post_run", running, 0);
    chk("t6_post_d", digits_bcd, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/countdown_timer_core.md
Name: countdown_timer_core

Overview:
Parametrised successor to the fixed-duration kitchen timer. Provides a programmable up/down seconds timer with an internal prescaler, NUM_PAIRS base-60 BCD digit pairs (SS, MM, HH...), pause/resume, and a sticky alarm. Sits between the PLL-derived slow clock and the per-digit 7-segment decoders; the digit outputs drive the display chain directly.

Parameters:
TICKS_PER_SEC, 10000, clk cycles per one-second tick (>=2)
NUM_PAIRS, 3, number of base-60 digit pairs (ones 0-9, tens 0-5); 3 = HH:MM:SS

Ports:
clk  in  1  timer clock
rst  in  1  asynchronous, active-high reset
load  in  1  pulse: capture preset_bcd into preset register
preset_bcd  in  8*NUM_PAIRS  target time, BCD, pair 0 = seconds, ones nibble lowest
mode  in  1  0 = count up to preset, 1 = count down from preset; sampled on start
start  in  1  pulse: begin run from IDLE or DONE
pause  in  1  pulse: toggle RUN/PAUSE
clear  in  1  pulse: abort, zero count, drop alarm
digits_bcd  out  8*NUM_PAIRS  current count, same packing as preset_bcd
running  out  1  high in RUN
paused  out  1  high in PAUSE
alarm  out  1  sticky: target reached
alarm_blink  out  1  display-blink form of alarm (see Optional Feature)
load_err  out  1  one-cycle pulse: rejected preset

Behaviour:
- Reset: state IDLE, prescaler 0, preset 0, count 0, mode_q 0; all outputs 0.
- States: IDLE, RUN, PAUSE, DONE. Registered outputs update one cycle after the causing input.
- Input priority in one cycle: clear > load > start > pause; lower-priority pulses in that cycle are ignored.
- clear (any state) -> IDLE; count 0, prescaler 0, alarm 0.
- load: accepted in IDLE and DONE only; ignored silently in RUN/PAUSE. Any nibble invalid (ones >9 or tens >5) -> preset unchanged, load_err pulses 1 cycle. Valid -> preset updated; count unchanged.
- start in IDLE/DONE: mode_q <= mode; prescaler 0; alarm 0; count <= preset (down) or 0 (up). If preset == 0 -> DONE next cycle with alarm 1, else RUN. start ignored in RUN/PAUSE.
- pause: RUN -> PAUSE, PAUSE -> RUN; ignored in IDLE/DONE. Prescaler holds in PAUSE, so a resumed second completes the remaining fraction.
- Prescaler: counts 0..TICKS_PER_SEC-1 in RUN only. sec_tick when it equals TICKS_PER_SEC-1; wraps to 0.
- On sec_tick, down mode: BCD decrement with borrow (ones 0 -> 9 borrow; tens 0 -> 5 borrow across pairs). If the result is 0 -> DONE, alarm 1 in the same cycle the count shows 0.
- On sec_tick, up mode: BCD increment with carry (ones 9 -> 0 carry; tens 5 -> 0 carry to next pair). If the result == preset -> DONE, alarm 1. The all-59 maximum can never be exceeded because preset is bounded.
- DONE: count frozen at final value; alarm held until clear or start.
- Reset asserted mid-run returns to reset values asynchronously. The prescaler restarts cleanly after release.

Optional Feature:
ALARM_BLINK_EN. When defined: in DONE, alarm_blink toggles every TICKS_PER_SEC/2 cycles, starting at 1 on DONE entry, using a dedicated half-second counter. It is 0 outside DONE. When undefined: no extra counter; alarm_blink = alarm.

Test Plan:
1. TICKS_PER_SEC=4. Load 00:00:03, mode 1, start -> digits go 03,02,01,00 at 4-cycle intervals. alarm rises with 00 (cycle 12 after RUN entry); running drops.
2. Load 00:01:00, mode 1, start -> after the first tick digits = 00:00:59 (borrow across pair). Then load 00:00:02, mode 0, start -> 00,01,02; alarm at 02.
3. Run down from 00:00:05, pause at cycle 6 and hold 10 cycles, then resume -> next tick arrives 2 cycles after resume; paused high during hold; count frozen at 04.
4. Load with seconds tens = 6 (0x65) -> load_err single pulse; preset unchanged (start reproduces the old preset). Load during RUN -> no effect, no load_err.
5. Load 0, start in either mode -> DONE and alarm 1 on the next cycle. In the same DONE cycle, assert clear+start -> clear wins: IDLE, alarm 0, count 0.
6. With ALARM_BLINK_EN and TICKS_PER_SEC=4 -> after DONE, alarm_blink pattern 1,1,0,0,1,1... Without the macro -> alarm_blink tracks alarm. Async rst mid-RUN -> all outputs 0 immediately.
